// File: rtl/uart_frame_tx.sv
// UART frame transmitter: 0x55/0xAA header, 16-bit timestamp, payload bytes, additive checksum.
// One start bit, 8 data bits LSB first, optional parity, one stop bit; characters sent back-to-back.
module uart_frame_tx #(
    parameter int OSC_FREQ   = 20_000_000,
    parameter int BAUD       = 115200,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0,
    parameter int N_PAYLOAD  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Frame_Start,
    input  logic [15:0]            Frame_Ms,
    input  logic [8*N_PAYLOAD-1:0] Frame_Payload,
    output logic                   Tx_Out,
    output logic                   Tx_Busy,
    output logic                   Frame_Done,
    output logic                   Frame_Drop
);

    localparam int DIV   = OSC_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(N_PAYLOAD + 5);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAYLOAD + 4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         baud_cnt;
    logic [2:0]               bit_cnt;
    logic [2:0]               nxt_bit;
    logic [IDX_W-1:0]         byte_idx;
    logic [IDX_W-1:0]         next_idx;
    logic [7:0]               cur_byte;
    logic [7:0]               next_byte;
    logic [7:0]               chk;
    logic [15:0]              ms_q;
    logic [8*N_PAYLOAD-1:0]   pay_q;
    logic                     bit_end;
    logic                     tx_d;

    assign bit_end  = (baud_cnt == CNT_W'(DIV - 1));
    assign nxt_bit  = bit_cnt + 3'd1;
    assign next_idx = byte_idx + IDX_W'(1);
    assign Tx_Busy  = (state_q != IDLE);

    // Byte that follows the current one in the frame; the checksum slot reads the running sum.
    always_comb begin
        next_byte = 8'h55;
        if (next_idx == IDX_W'(1))
            next_byte = 8'hAA;
        else if (next_idx == IDX_W'(2))
            next_byte = ms_q[15:8];
        else if (next_idx == IDX_W'(3))
            next_byte = ms_q[7:0];
        else if (next_idx == LAST_IDX)
            next_byte = chk;
        for (int i = 0; i < N_PAYLOAD; i++) begin
            if (next_idx == IDX_W'(i + 4))
                next_byte = pay_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = Tx_Out;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (Frame_Start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = (^cur_byte) ^ PARITY_ODD;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = cur_byte[nxt_bit];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == LAST_IDX) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            Tx_Out  <= 1'b1;
        end else begin
            state_q <= state_d;
            Tx_Out  <= tx_d;
        end
    end

    // Acceptance restarts the baud phase and the checksum; later bytes add in as they are loaded.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            cur_byte   <= '0;
            chk        <= '0;
            ms_q       <= '0;
            pay_q      <= '0;
            Frame_Done <= 1'b0;
            Frame_Drop <= 1'b0;
        end else begin
            Frame_Done <= (state_q == STOP) && bit_end && (byte_idx == LAST_IDX);
            Frame_Drop <= Frame_Start && (state_q != IDLE);
            if (state_q == IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
                if (Frame_Start) begin
                    ms_q     <= Frame_Ms;
                    pay_q    <= Frame_Payload;
                    byte_idx <= '0;
                    cur_byte <= 8'h55;
                    chk      <= '0;
                end
            end else begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
                if (state_q == DATA && bit_end)
                    bit_cnt <= nxt_bit;
                if (state_q == STOP && bit_end && byte_idx != LAST_IDX) begin
                    byte_idx <= next_idx;
                    cur_byte <= next_byte;
                    if (next_idx >= IDX_W'(2) && next_idx < LAST_IDX)
                        chk <= chk + next_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three instances (even, odd, no parity) checked against an
// arithmetic model of the expected line level at every bit boundary.
module tb_uart_frame_tx;

    localparam int OSC = 1_000_000;
    localparam int BR  = 100_000;
    localparam int DIV = 10;
    localparam int NP  = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [2:0]  start;
    logic [15:0] ms;
    logic [15:0] pay;
    logic        tx_o   [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        drop_o [3];

    int checks = 0;
    int errors = 0;
    int pen  [3] = '{1, 1, 0};
    int podd [3] = '{0, 1, 0};

    always #5 CLK = ~CLK;

    uart_frame_tx #(.OSC_FREQ(OSC), .BAUD(BR), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .N_PAYLOAD(NP)) dut_even (
        .CLK(CLK), .RST(RST), .Frame_Start(start[0]), .Frame_Ms(ms), .Frame_Payload(pay),
        .Tx_Out(tx_o[0]), .Tx_Busy(busy_o[0]), .Frame_Done(done_o[0]), .Frame_Drop(drop_o[0]));

    uart_frame_tx #(.OSC_FREQ(OSC), .BAUD(BR), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .N_PAYLOAD(NP)) dut_odd (
        .CLK(CLK), .RST(RST), .Frame_Start(start[1]), .Frame_Ms(ms), .Frame_Payload(pay),
        .Tx_Out(tx_o[1]), .Tx_Busy(busy_o[1]), .Frame_Done(done_o[1]), .Frame_Drop(drop_o[1]));

    uart_frame_tx #(.OSC_FREQ(OSC), .BAUD(BR), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .N_PAYLOAD(NP)) dut_nopar (
        .CLK(CLK), .RST(RST), .Frame_Start(start[2]), .Frame_Ms(ms), .Frame_Payload(pay),
        .Tx_Out(tx_o[2]), .Tx_Busy(busy_o[2]), .Frame_Done(done_o[2]), .Frame_Drop(drop_o[2]));

    // Seven frame bytes packed LSB-first: header, timestamp, payload, checksum.
    function automatic logic [55:0] make_frame(input logic [15:0] m, input logic [15:0] p);
        int sum;
        sum = (int'(m[15:8]) + int'(m[7:0]) + int'(p[7:0]) + int'(p[15:8])) % 256;
        return {8'(sum), p[15:8], p[7:0], m[7:0], m[15:8], 8'hAA, 8'h55};
    endfunction

    // Line level t cycles after the accepting edge.
    function automatic logic exp_level(input int d, input logic [55:0] fb, input int t);
        int bpc, bitn, ch, pos;
        logic [7:0] b;
        bpc  = 10 + pen[d];
        bitn = t / DIV;
        ch   = bitn / bpc;
        pos  = bitn % bpc;
        if (ch >= 7) return 1'b1;
        b = fb[8*ch +: 8];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9 && pen[d] == 1) return (^b) ^ 1'(podd[d]);
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic [15:0] m, input logic [15:0] p);
        start = mask;
        ms    = m;
        pay   = p;
    endtask

    // Runs one frame from the accepting edge, optionally with a busy-time request, a chained
    // restart in the done cycle, or a reset mid-frame.
    task automatic run_frame(input logic [2:0] mask, input logic [15:0] m, input logic [15:0] p,
                             input int drop_at, input bit chain, input logic [15:0] cm,
                             input logic [15:0] cp, input int reset_at);
        logic [55:0] fb;
        int ndone [3];
        int len   [3];
        int lim;
        fb  = make_frame(m, p);
        lim = 7 * 11 * DIV + 3;
        for (int d = 0; d < 3; d++) begin
            ndone[d] = 0;
            len[d]   = 7 * (10 + pen[d]) * DIV;
        end
        @(posedge CLK); #1;
        start = '0;
        for (int t = 0; t <= lim; t++) begin
            if (t > 0) begin
                @(posedge CLK); #1;
            end
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    if (done_o[d] === 1'b1) ndone[d]++;
                    if (reset_at >= 0 && t > reset_at) begin
                        if (t == reset_at + 1 || t == lim) begin
                            checkOutput("reset_tx", d, tx_o[d], 1);
                            checkOutput("reset_busy", d, busy_o[d], 0);
                        end
                    end else if (t < len[d]) begin
                        if (t % DIV == 0 || t % DIV == DIV - 1) begin
                            checkOutput("tx_bit", d, tx_o[d], exp_level(d, fb, t));
                            checkOutput("busy", d, busy_o[d], 1);
                        end
                        if (t == 5) checkOutput("no_drop", d, drop_o[d], 0);
                    end else if (t == len[d]) begin
                        checkOutput("done_pulse", d, done_o[d], 1);
                        checkOutput("busy_at_done", d, busy_o[d], 0);
                    end else if (t == lim) begin
                        checkOutput("idle_tx", d, tx_o[d], 1);
                        checkOutput("idle_busy", d, busy_o[d], 0);
                    end
                end
            end
            if (drop_at >= 0 && t == drop_at + 1) checkOutput("drop_pulse", 0, drop_o[0], 1);
            if (drop_at >= 0 && t == drop_at + 2) checkOutput("drop_single", 0, drop_o[0], 0);
            ms    = 16'($urandom);
            pay   = 16'($urandom);
            start = '0;
            if (t == drop_at) start[0] = 1'b1;
            if (reset_at >= 0 && t == reset_at) RST = 1'b0;
            if (reset_at >= 0 && t == reset_at + 4) RST = 1'b1;
            if (chain && t == len[0]) begin
                applyStimulus(3'b001, cm, cp);
                break;
            end
        end
        for (int d = 0; d < 3; d++)
            if (mask[d]) checkOutput("done_count", d, ndone[d], (reset_at >= 0) ? 0 : 1);
    endtask

    initial begin
        logic [15:0] m1, p1, m2, p2;
        start = '0;
        ms    = '0;
        pay   = '0;
        RST   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_tx", d, tx_o[d], 1);
            checkOutput("rst_busy", d, busy_o[d], 0);
            checkOutput("rst_done", d, done_o[d], 0);
            checkOutput("rst_drop", d, drop_o[d], 0);
        end
        RST = 1'b1;
        @(posedge CLK); #1;

        $display("[TB] directed frame 03E7 / 1234 on all parity variants");
        applyStimulus(3'b111, 16'h03E7, 16'h1234);
        run_frame(3'b111, 16'h03E7, 16'h1234, -1, 1'b0, 16'h0, 16'h0, -1);

        $display("[TB] random frames");
        repeat (4) begin
            m1 = 16'($urandom);
            p1 = 16'($urandom);
            applyStimulus(3'b111, m1, p1);
            run_frame(3'b111, m1, p1, -1, 1'b0, 16'h0, 16'h0, -1);
        end

        $display("[TB] request while busy");
        m1 = 16'($urandom);
        p1 = 16'($urandom);
        applyStimulus(3'b001, m1, p1);
        run_frame(3'b001, m1, p1, 200, 1'b0, 16'h0, 16'h0, -1);

        $display("[TB] restart in the done cycle");
        m1 = 16'($urandom);
        p1 = 16'($urandom);
        m2 = 16'($urandom);
        p2 = 16'($urandom);
        applyStimulus(3'b001, m1, p1);
        run_frame(3'b001, m1, p1, -1, 1'b1, m2, p2, -1);
        run_frame(3'b001, m2, p2, -1, 1'b0, 16'h0, 16'h0, -1);

        $display("[TB] reset mid data bit, then a full frame");
        m1 = 16'($urandom);
        p1 = 16'($urandom);
        applyStimulus(3'b111, m1, p1);
        run_frame(3'b111, m1, p1, -1, 1'b0, 16'h0, 16'h0, 3 * 11 * DIV + 4 * DIV + 3);
        m1 = 16'($urandom);
        p1 = 16'($urandom);
        applyStimulus(3'b111, m1, p1);
        run_frame(3'b111, m1, p1, -1, 1'b0, 16'h0, 16'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
